mib_slave: RTL
==============

# mib_slave

Responder end of the MIB bus: a per-FPGA slave that captures the master's two 16-bit address phases and optional two 16-bit write-data phases. It then issues one transaction on the local `intf_cmd` register bus and answers on the MIB with `o_mib_slave_ack` and, for reads, two 16-bit read-data phases. It sits at the top of each board FPGA, behind the pad I/O registers, and bridges the board-level MIB to the FPGA's internal command fabric.

## Interface
- `P_SLAVE_MSN`, 4'h0: byte-address bits [23:20] that select this slave.
- `P_CMD_ACK_TIMEOUT_CLKS`, 16: clocks to wait for local `ack` after `sel`.
- `P_TIMEOUT_RDATA`, 32'hDEAD_BEEF: read data returned when the local bus times out.
- `i_sysclk`, in, 1: sole clock; MIB and cmd bus are synchronous to it.
- `i_arst_n`, in, 1: asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- `i_mib_start`, in, 1: one-clock pulse marking address phase 1.
- `i_mib_rd_wr_n`, in, 1: sampled with start; 1 means read, 0 means write.
- `i_mib_ad`, in, 16: address/write-data phases from the master.
- `o_mib_ad`, out, 16: read-data phases.
- `o_mib_ad_high_z`, out, 1: 1 means the top level tri-states the pad; 0 means drive.
- `o_mib_slave_ack`, out, 1: write ack (one pulse) or read-data valid (two cycles).
- `cmd_master`, modport, `intf_cmd #(24,32)` master side: `sel`, `rd_wr_n`, `byte_addr`, `wdata` out; `rdata`, `ack` in.
- `o_cmd_timeout`, out, 1: one-clock pulse when the local cmd ack times out.

## Operation
- **Phase encoding.**
  - A1 (start=1): `ad[7:0]` carries `addr[23:16]`; `ad[15:8]` is ignored.
  - A2: `ad` carries `addr[15:0]`.
  - Write only: D1 carries `wdata[31:16]`, then D2 carries `wdata[15:0]`, on consecutive clocks.
- **FSM states:** IDLE, ADDR2, WDATA1, WDATA2, SKIP_W1, SKIP_W2, CMD, RDATA1, RDATA2, WACK.
- **IDLE.** Start is sampled only in IDLE. When start=1, latch `rd_wr_n` and `addr[23:16]`, then go to ADDR2. Start in any other state is ignored.
- **ADDR2.** Latch `addr[15:0]`, then branch:
  - If `addr[23:20]` != `P_SLAVE_MSN`: a write goes to SKIP_W1 → SKIP_W2 → IDLE; a read goes to IDLE. The bus is never driven, there is no ack and no cmd access.
  - If it matches: a write goes to WDATA1 → WDATA2; a read goes to CMD.
- **WDATA2 → CMD.** On entry to CMD, `cmd_master.sel`=1 for exactly one clock, with `byte_addr`, `rd_wr_n` and `wdata` held stable until `ack`.
- **CMD, on `ack`.**
  - Write: go to WACK, where `o_mib_slave_ack`=1 for one clock, then IDLE.
  - Read: capture `rdata`, then RDATA1 drives `rdata[31:16]` and RDATA2 drives `rdata[15:0]`.
  - In both RDATA states `high_z`=0 and `ack`=1. After RDATA2, `high_z`=1 and the FSM returns to IDLE.
- **Timeout** (only with the macro): the counter is cleared on `sel` and counts each CMD cycle. On reaching `P_CMD_ACK_TIMEOUT_CLKS` with no `ack`, pulse `o_cmd_timeout`.
  - Read: return `P_TIMEOUT_RDATA` via RDATA1/RDATA2.
  - Write: go to IDLE with no MIB ack.
- **Simultaneous events.**
  - `ack` in the same cycle the counter terminates: `ack` wins, with no timeout pulse.
  - A late `ack` arriving in IDLE is ignored.

## Timing
- **Reset values:** FSM=IDLE, `o_mib_ad`=0, `o_mib_ad_high_z`=1, `o_mib_slave_ack`=0, `sel`=0, `o_cmd_timeout`=0. All outputs are registered.
- **Reset mid-operation:** the bus releases asynchronously and the cmd `sel` drops. The pending local transaction is abandoned.
- **Write latency:** A1 at cycle 0, A2 at 1, D1 at 2, D2 at 3, `sel` at 4. With local `ack` at cycle 4+k, `o_mib_slave_ack` is high at 5+k.
- **Read latency:** A1 at 0, A2 at 1, `sel` at 2. With `ack` at 2+k, RDATA1 is at 3+k and RDATA2 at 4+k, and `high_z` returns to 1 at 5+k.
- **Back-to-back:** a new A1 is accepted on the first clock back in IDLE, i.e. the clock after WACK, RDATA2 or SKIP_W2.
- **Pad registers:** the top-level pad registers add one clock each way. Their total must stay within the master's `P_MIB_ACK_TIMEOUT_CLKS`.

## Configuration
- `MIB_SLAVE_CMD_TIMEOUT_EN`
  - Defined: the timeout counter is built and the timeout behaviour above applies.
  - Undefined: CMD waits indefinitely for `ack`, and `o_cmd_timeout` is tied to 0.

## Structure
- **`mib_pkg`:** FSM state enum, `MIB_AD_BITS`=16, `CMD_ADDR_BITS`=24, `CMD_DATA_BITS`=32, and MSN field position constants [23:20].
- **Sub-module `mib_slave_cmd_timer`:** clear/enable counter with a terminal-count pulse. It is instantiated only under the macro.

## Test plan
- **Write:** write addr 0x000004, data 0x01010202, local `ack` after 2 clocks. Expect one `sel` with `byte_addr`=0x000004 and `wdata`=0x01010202, and a single `o_mib_slave_ack` pulse.
- **Read:** read 0x000008 with local `rdata`=0xCAFE1234. Expect `o_mib_ad`=0xCAFE then 0x1234 on consecutive clocks, with `ack`=1 for both and `high_z`=0 only during those two clocks.
- **MSN mismatch:** read and write to 0x500000 with `P_SLAVE_MSN`=0. Expect no `sel`, no ack, `high_z` held at 1, and the FSM back in IDLE.
- **Timeout** (macro on): local bus never acks a read of 0x000010. Expect `o_cmd_timeout` 16 clocks after `sel`, MIB data 0xDEAD/0xBEEF, and a later `ack` ignored.
- **Reset mid-read:** assert `i_arst_n`=0 during RDATA1. Expect `high_z`=1, `ack`=0 and `sel`=0 immediately (asynchronously). The next read completes normally.
- **Back-to-back and start-ignored:** write then read with A1 on the clock after WACK; both complete. A stray start during WDATA1 is ignored.

Source files
------------

// File: rtl/mib_pkg.sv
// Shared types and constants for the MIB slave: FSM states, bus widths and
// the position of the slave-select nibble inside the 24-bit byte address.
package mib_pkg;

  localparam int MIB_AD_BITS   = 16;
  localparam int CMD_ADDR_BITS = 24;
  localparam int CMD_DATA_BITS = 32;
  localparam int MSN_HI        = 23;
  localparam int MSN_LO        = 20;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR2,
    ST_WDATA1,
    ST_WDATA2,
    ST_SKIP_W1,
    ST_SKIP_W2,
    ST_CMD,
    ST_RDATA1,
    ST_RDATA2,
    ST_WACK
  } state_t;

  // True in the two states where the slave owns the MIB data pads.
  function automatic logic drives_bus(state_t s);
    return (s == ST_RDATA1) || (s == ST_RDATA2);
  endfunction

endpackage

// File: rtl/mib_slave_if.sv
// Local register command bus (intf_cmd): one-clock sel, qualifiers held
// until the responder returns ack (with rdata for reads).
interface intf_cmd #(
  parameter int ADDR_BITS = 24,
  parameter int DATA_BITS = 32
) ();

  logic                 sel;
  logic                 rd_wr_n;
  logic [ADDR_BITS-1:0] byte_addr;
  logic [DATA_BITS-1:0] wdata;
  logic [DATA_BITS-1:0] rdata;
  logic                 ack;

  modport master (output sel, rd_wr_n, byte_addr, wdata, input rdata, ack);
  modport slave  (input sel, rd_wr_n, byte_addr, wdata, output rdata, ack);

endinterface

// File: rtl/mib_slave_cmd_timer.sv
// Clear/enable cycle counter for the local ack timeout; tc is high in the
// LIMIT-th enabled cycle counted from the cycle in which clear is asserted.
module mib_slave_cmd_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;
  logic [W-1:0] base;

  // The clear cycle itself is counted as cycle zero.
  assign base = clear ? '0 : cnt;
  assign tc   = en && (base == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= base + W'(1);
    end else begin
      cnt <= base;
    end
  end

endmodule

// File: rtl/mib_slave.sv
// MIB bus responder bridging to the local intf_cmd register bus.
// Optional local ack timeout is built when MIB_SLAVE_CMD_TIMEOUT_EN is defined.
module mib_slave
  import mib_pkg::*;
#(
  parameter logic [3:0]  P_SLAVE_MSN            = 4'h0,
  parameter int          P_CMD_ACK_TIMEOUT_CLKS = 16,
  parameter logic [31:0] P_TIMEOUT_RDATA        = 32'hDEAD_BEEF
) (
  input  logic                   i_sysclk,
  input  logic                   i_arst_n,
  input  logic                   i_mib_start,
  input  logic                   i_mib_rd_wr_n,
  input  logic [MIB_AD_BITS-1:0] i_mib_ad,
  output logic [MIB_AD_BITS-1:0] o_mib_ad,
  output logic                   o_mib_ad_high_z,
  output logic                   o_mib_slave_ack,
  intf_cmd.master                cmd_master,
  output logic                   o_cmd_timeout
);

  state_t                   state, next_state;
  logic                     rd_wr_n_q;
  logic [CMD_ADDR_BITS-1:0] addr_q;
  logic [CMD_DATA_BITS-1:0] wdata_q;
  logic [MIB_AD_BITS-1:0]   rdata_lo_q;
  logic [CMD_DATA_BITS-1:0] cmd_result;
  logic                     msn_hit;
  logic                     tmo_tc;

  assign msn_hit    = (addr_q[MSN_HI:MSN_LO] == P_SLAVE_MSN);
  assign cmd_result = cmd_master.ack ? cmd_master.rdata : P_TIMEOUT_RDATA;

  assign cmd_master.rd_wr_n   = rd_wr_n_q;
  assign cmd_master.byte_addr = addr_q;
  assign cmd_master.wdata     = wdata_q;

`ifdef MIB_SLAVE_CMD_TIMEOUT_EN
  mib_slave_cmd_timer #(.LIMIT(P_CMD_ACK_TIMEOUT_CLKS)) u_cmd_timer (
    .clk   (i_sysclk),
    .rst_n (i_arst_n),
    .clear (cmd_master.sel),
    .en    (state == ST_CMD),
    .tc    (tmo_tc)
  );

  // A local ack in the terminal cycle wins over the timeout.
  always_ff @(posedge i_sysclk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_cmd_timeout <= 1'b0;
    end else begin
      o_cmd_timeout <= (state == ST_CMD) && tmo_tc && !cmd_master.ack;
    end
  end
`else
  assign tmo_tc        = 1'b0;
  assign o_cmd_timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: next_state is defaulted before the case so no path leaves it unassigned (no latch).
    next_state = state;
    case (state)
      ST_IDLE:    if (i_mib_start) next_state = ST_ADDR2;
      ST_ADDR2: begin
        if (!msn_hit) next_state = rd_wr_n_q ? ST_IDLE : ST_SKIP_W1;
        else          next_state = rd_wr_n_q ? ST_CMD  : ST_WDATA1;
      end
      ST_WDATA1:  next_state = ST_WDATA2;
      ST_WDATA2:  next_state = ST_CMD;
      ST_SKIP_W1: next_state = ST_SKIP_W2;
      ST_SKIP_W2: next_state = ST_IDLE;
      ST_CMD: begin
        if (cmd_master.ack) next_state = rd_wr_n_q ? ST_RDATA1 : ST_WACK;
        else if (tmo_tc)    next_state = rd_wr_n_q ? ST_RDATA1 : ST_IDLE;
      end
      ST_RDATA1:  next_state = ST_RDATA2;
      ST_RDATA2:  next_state = ST_IDLE;
      ST_WACK:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sysclk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state           <= ST_IDLE;
      rd_wr_n_q       <= 1'b1;
      addr_q          <= '0;
      wdata_q         <= '0;
      rdata_lo_q      <= '0;
      cmd_master.sel  <= 1'b0;
      o_mib_ad        <= '0;
      o_mib_ad_high_z <= 1'b1;
      o_mib_slave_ack <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_IDLE && i_mib_start) begin
        rd_wr_n_q     <= i_mib_rd_wr_n;
        addr_q[23:16] <= i_mib_ad[7:0];
      end
      if (state == ST_ADDR2)  addr_q[15:0]   <= i_mib_ad;
      if (state == ST_WDATA1) wdata_q[31:16] <= i_mib_ad;
      if (state == ST_WDATA2) wdata_q[15:0]  <= i_mib_ad;
      if (state == ST_CMD && next_state == ST_RDATA1) rdata_lo_q <= cmd_result[15:0];

      cmd_master.sel  <= (next_state == ST_CMD) && (state != ST_CMD);
      o_mib_slave_ack <= (next_state == ST_WACK) || drives_bus(next_state);
      o_mib_ad_high_z <= !drives_bus(next_state);
      case (next_state)
        ST_RDATA1: o_mib_ad <= cmd_result[31:16];
        ST_RDATA2: o_mib_ad <= rdata_lo_q;
        default:   o_mib_ad <= '0;
      endcase
    end
  end

endmodule
